// File: rtl/pe_finish_reporter.sv
// End-of-simulation status aggregator: collects one pass/fail word per PE and raises a held finish request.
// Optional watchdog timeout is enabled by defining PE_FINISH_TIMEOUT_EN.
module pe_finish_reporter #(
  parameter int NUM_PE      = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                               sys_clk,
  input  logic                               sys_rstn,
  input  logic [NUM_PE-1:0]                  pe_wr_vld,
  output logic [NUM_PE-1:0]                  pe_wr_rdy,
  input  logic [NUM_PE*DATA_W-1:0]           pe_wr_data,
  output logic                               finish_vld,
  input  logic                               finish_ack,
  output logic                               finish_pass,
  output logic [((NUM_PE > 1) ? $clog2(NUM_PE) : 1)-1:0] finish_pe_id,
  output logic [15:0]                        finish_code,
  output logic [NUM_PE-1:0]                  done_mask,
  output logic                               bad_tag
);

  localparam int PE_ID_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam logic [15:0] TAG_PASS = 16'h600D;
  localparam logic [15:0] TAG_FAIL = 16'h0BAD;

  typedef enum logic [1:0] {
    ST_COLLECT,
    ST_REPORT,
    ST_DONE
  } state_t;

  state_t state, state_nxt;

  logic [NUM_PE-1:0]        acc;
  logic [NUM_PE-1:0]        fail_vec;
  logic [NUM_PE-1:0]        unk_vec;
  logic [NUM_PE-1:0]        mask_nxt;
  logic [NUM_PE-1:0][15:0]  tags;
  logic [NUM_PE-1:0][15:0]  codes;
  logic                     fail_found;
  logic [PE_ID_W-1:0]       fail_id;
  logic [15:0]              fail_code;
  logic                     load_verdict;
  logic                     verdict_pass;
  logic [PE_ID_W-1:0]       verdict_id;
  logic [15:0]              verdict_code;

  always_comb begin
    for (int i = 0; i < NUM_PE; i++) begin
      tags[i]  = pe_wr_data[i*DATA_W+16 +: 16];
      codes[i] = pe_wr_data[i*DATA_W +: 16];
    end
  end

  assign pe_wr_rdy  = (state == ST_COLLECT) ? ~done_mask : '0;
  assign finish_vld = (state == ST_REPORT);
  assign acc        = pe_wr_vld & pe_wr_rdy;
  assign mask_nxt   = done_mask | acc;

  // NOTE: every variable gets a default before the branches so no latch is inferred.
  always_comb begin
    fail_vec   = '0;
    unk_vec    = '0;
    fail_found = 1'b0;
    fail_id    = '0;
    fail_code  = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (acc[i]) begin
        if (tags[i] == TAG_FAIL)      fail_vec[i] = 1'b1;
        else if (tags[i] != TAG_PASS) unk_vec[i]  = 1'b1;
      end
    end
    // Lowest-index failing PE of this cycle owns the verdict.
    for (int i = 0; i < NUM_PE; i++) begin
      if (fail_vec[i] && !fail_found) begin
        fail_found = 1'b1;
        fail_id    = PE_ID_W'(i);
        fail_code  = codes[i];
      end
    end
  end

`ifdef PE_FINISH_TIMEOUT_EN
  logic [31:0]        wd_cnt;
  logic               wd_hit;
  logic               idle_found;
  logic [PE_ID_W-1:0] idle_id;

  assign wd_hit = (state == ST_COLLECT) && (wd_cnt == 32'(TIMEOUT_CYC - 1));

  always_comb begin
    idle_found = 1'b0;
    idle_id    = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (!mask_nxt[i] && !idle_found) begin
        idle_found = 1'b1;
        idle_id    = PE_ID_W'(i);
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn)                wd_cnt <= '0;
    else if (state == ST_COLLECT) wd_cnt <= wd_cnt + 32'd1;
  end
`else
  logic timeout_unused;
  assign timeout_unused = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_nxt    = state;
    load_verdict = 1'b0;
    verdict_pass = 1'b0;
    verdict_id   = '0;
    verdict_code = '0;
    case (state)
      ST_COLLECT: begin
        // A fail outranks completion, and both outrank the watchdog.
        if (fail_found) begin
          state_nxt    = ST_REPORT;
          load_verdict = 1'b1;
          verdict_id   = fail_id;
          verdict_code = fail_code;
        end else if (&mask_nxt) begin
          state_nxt    = ST_REPORT;
          load_verdict = 1'b1;
          verdict_pass = 1'b1;
        end
`ifdef PE_FINISH_TIMEOUT_EN
        else if (wd_hit) begin
          state_nxt    = ST_REPORT;
          load_verdict = 1'b1;
          verdict_id   = idle_id;
          verdict_code = 16'hDEAD;
        end
`endif
      end
      ST_REPORT: if (finish_ack) state_nxt = ST_DONE;
      ST_DONE:   state_nxt = ST_DONE;
      default:   state_nxt = ST_COLLECT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) state <= ST_COLLECT;
    else           state <= state_nxt;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      done_mask    <= '0;
      bad_tag      <= 1'b0;
      finish_pass  <= 1'b0;
      finish_pe_id <= '0;
      finish_code  <= '0;
    end else begin
      done_mask <= mask_nxt;
      if (|unk_vec) bad_tag <= 1'b1;
      if (load_verdict) begin
        finish_pass  <= verdict_pass;
        finish_pe_id <= verdict_id;
        finish_code  <= verdict_code;
      end
    end
  end

endmodule
